// File: rtl/acc_bias_128.sv
// Accumulates ACC_LEN signed products, adds a per-channel bias on the last beat,
// and holds the result with a valid/ready handshake for the 128-bound saturation stage.
module acc_bias_128 #(
    parameter int P_BW    = 16,
    parameter int B_BW    = 16,
    parameter int AB_BW   = 21,
    parameter int ACC_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [P_BW-1:0]  i_product,
    input  logic [B_BW-1:0]  i_bias,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [AB_BW-1:0] o_acc_bias,
    output logic             o_busy
);

    localparam int CNT_BW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(ACC_LEN - 1);

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    state_t                   state;
    logic signed [AB_BW-1:0]  acc;
    logic        [CNT_BW-1:0] cnt;

    logic signed [P_BW-1:0]   prod_s;
    logic signed [B_BW-1:0]   bias_s;
    logic signed [AB_BW-1:0]  prod_ext;
    logic signed [AB_BW-1:0]  bias_ext;
    logic                     beat;

    assign prod_s   = i_product;
    assign bias_s   = i_bias;
    assign prod_ext = AB_BW'(prod_s);
    assign bias_ext = AB_BW'(bias_s);

    // An output handshake and a new product can never share a cycle: ready only in S_ACC.
    assign o_ready = (state == S_ACC) && !i_clear;
    assign o_valid = (state == S_OUT);
    assign o_busy  = (cnt != '0) || (state == S_OUT);
    assign beat    = i_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_ACC;
            acc        <= '0;
            cnt        <= '0;
            o_acc_bias <= '0;
        end else if (i_clear) begin
            state <= S_ACC;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (beat) begin
                        if (cnt == LAST_CNT) begin
                            o_acc_bias <= acc + prod_ext + bias_ext;
                            acc        <= '0;
                            cnt        <= '0;
                            state      <= S_OUT;
                        end else begin
                            acc <= acc + prod_ext;
                            cnt <= cnt + CNT_BW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        state <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_bias_128.sv
// Directed bench for acc_bias_128: ACC_LEN=4, default ACC_LEN=16 and ACC_LEN=1 instances
// share one stimulus bus; each group result is compared against hand-computed values.
module tb_acc_bias_128;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clear;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_product;
    logic [15:0] i_bias;

    logic        o_ready4, o_valid4, o_busy4;
    logic [20:0] o_acc4;
    logic        o_ready16, o_valid16, o_busy16;
    logic [20:0] o_acc16;
    logic        o_ready1, o_valid1, o_busy1;
    logic [20:0] o_acc1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] p3;
        logic [15:0] bias;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs [6];

    acc_bias_128 #(.ACC_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready4),
        .i_product(i_product), .i_bias(i_bias), .o_valid(o_valid4), .i_ready(i_ready),
        .o_acc_bias(o_acc4), .o_busy(o_busy4)
    );

    acc_bias_128 dut16 (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready16),
        .i_product(i_product), .i_bias(i_bias), .o_valid(o_valid16), .i_ready(i_ready),
        .o_acc_bias(o_acc16), .o_busy(o_busy16)
    );

    acc_bias_128 #(.ACC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready1),
        .i_product(i_product), .i_bias(i_bias), .o_valid(o_valid1), .i_ready(i_ready),
        .o_acc_bias(o_acc1), .o_busy(o_busy1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAcc(input string name, input logic [20:0] act, input logic [20:0] exp);
        checkOutput(name, {11'b0, act}, {11'b0, exp});
    endtask

    // Presents one beat for exactly one rising edge, then samples 1 time unit after it.
    task automatic applyStimulus(input logic [15:0] prod, input logic [15:0] bias);
        i_valid   = 1'b1;
        i_product = prod;
        i_bias    = bias;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic releaseOutput();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'd10, 16'd20, -16'sd5, 16'd3, 16'd100, 21'd128};
        vecs[1] = '{-16'sd300, -16'sd300, -16'sd300, -16'sd300, -16'sd100, 21'h1FFAEC};
        vecs[2] = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd0, 21'd16};
        vecs[3] = '{16'd50, 16'd50, 16'd50, 16'd50, 16'd0, 21'd200};
        vecs[4] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 21'd4};
        vecs[5] = '{-16'sd7, 16'd7, -16'sd7, 16'd7, 16'd9, 21'd9};

        rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_product = '0; i_bias = '0;

        #12;
        checkOutput("rst_valid4", {31'b0, o_valid4}, 32'd0);
        checkAcc("rst_acc4", o_acc4, 21'd0);
        checkOutput("rst_busy4", {31'b0, o_busy4}, 32'd0);
        checkOutput("rst_valid16", {31'b0, o_valid16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready4", {31'b0, o_ready4}, 32'd1);

        // Table-driven groups on the ACC_LEN=4 instance
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].p0, vecs[i].bias);
            checkOutput($sformatf("v%0d_busy", i), {31'b0, o_busy4}, 32'd1);
            applyStimulus(vecs[i].p1, vecs[i].bias);
            applyStimulus(vecs[i].p2, vecs[i].bias);
            checkOutput($sformatf("v%0d_early_valid", i), {31'b0, o_valid4}, 32'd0);
            applyStimulus(vecs[i].p3, vecs[i].bias);
            checkOutput($sformatf("v%0d_valid", i), {31'b0, o_valid4}, 32'd1);
            checkAcc($sformatf("v%0d_acc", i), o_acc4, vecs[i].exp);
            checkOutput($sformatf("v%0d_ready_out", i), {31'b0, o_ready4}, 32'd0);
            releaseOutput();
            checkOutput($sformatf("v%0d_valid_drop", i), {31'b0, o_valid4}, 32'd0);
            checkAcc($sformatf("v%0d_acc_hold", i), o_acc4, vecs[i].exp);
        end

        // Backpressure: beats offered while holding the result must be ignored
        applyStimulus(16'd10, 16'd100);
        applyStimulus(16'd20, 16'd100);
        applyStimulus(-16'sd5, 16'd100);
        applyStimulus(16'd3, 16'd100);
        i_valid   = 1'b1;
        i_product = 16'd99;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkAcc($sformatf("bp%0d_acc", k), o_acc4, 21'd128);
            checkOutput($sformatf("bp%0d_ready", k), {31'b0, o_ready4}, 32'd0);
            checkOutput($sformatf("bp%0d_valid", k), {31'b0, o_valid4}, 32'd1);
        end
        i_valid = 1'b0;
        releaseOutput();
        checkOutput("bp_busy_idle", {31'b0, o_busy4}, 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(16'd1, 16'd0);
        checkAcc("bp_next_acc", o_acc4, 21'd4);
        releaseOutput();

        // Gapped beats: two idle cycles between each
        for (int k = 0; k < 4; k++) begin
            applyStimulus(16'd7, -16'sd28);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    idle(1);
                    checkOutput($sformatf("gap%0d_%0d_valid", k, g), {31'b0, o_valid4}, 32'd0);
                end
            end
        end
        checkOutput("gap_valid", {31'b0, o_valid4}, 32'd1);
        checkAcc("gap_acc", o_acc4, 21'd0);
        releaseOutput();
        idle(2);
        checkOutput("gap_valid_once", {31'b0, o_valid4}, 32'd0);

        // i_clear after two beats; a beat presented with clear is dropped
        applyStimulus(16'd1000, 16'd0);
        applyStimulus(16'd1000, 16'd0);
        i_clear   = 1'b1;
        i_valid   = 1'b1;
        i_product = 16'd555;
        #1;
        checkOutput("clr_ready", {31'b0, o_ready4}, 32'd0);
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        checkOutput("clr_busy", {31'b0, o_busy4}, 32'd0);
        applyStimulus(16'd1, -16'sd1000);
        applyStimulus(16'd2, -16'sd1000);
        applyStimulus(16'd3, -16'sd1000);
        applyStimulus(16'd4, -16'sd1000);
        checkAcc("clr_acc", o_acc4, 21'h1FFC22);
        releaseOutput();

        // Asynchronous reset mid-group
        applyStimulus(16'd1000, 16'd0);
        applyStimulus(16'd1000, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'b0, o_valid4}, 32'd0);
        checkAcc("arst_acc", o_acc4, 21'd0);
        checkOutput("arst_busy", {31'b0, o_busy4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(16'd1, -16'sd1000);
        applyStimulus(16'd2, -16'sd1000);
        applyStimulus(16'd3, -16'sd1000);
        applyStimulus(16'd4, -16'sd1000);
        checkAcc("arst_next_acc", o_acc4, 21'h1FFC22);
        releaseOutput();

        // Default ACC_LEN=16 extremes
        pulseReset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(16'h7FFF, 16'h7FFF);
            if (k == 14) checkOutput("d16_early_valid", {31'b0, o_valid16}, 32'd0);
        end
        checkOutput("d16_pos_valid", {31'b0, o_valid16}, 32'd1);
        checkAcc("d16_pos_acc", o_acc16, 21'h087FEF);
        releaseOutput();
        for (int k = 0; k < 16; k++) applyStimulus(16'h8000, 16'h8000);
        checkOutput("d16_neg_valid", {31'b0, o_valid16}, 32'd1);
        checkAcc("d16_neg_acc", o_acc16, 21'h178000);
        releaseOutput();

        // ACC_LEN=1: every beat is a last beat
        pulseReset();
        applyStimulus(16'd5, 16'd7);
        checkOutput("d1_valid", {31'b0, o_valid1}, 32'd1);
        checkAcc("d1_acc", o_acc1, 21'd12);
        releaseOutput();
        applyStimulus(-16'sd3, -16'sd4);
        checkAcc("d1_acc_neg", o_acc1, 21'h1FFFF9);
        releaseOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_bias_128.md
Name: acc_bias_128

Overview:
- Accumulation stage directly upstream of the 128-bound saturation stage.
- Sums ACC_LEN signed products from the PE/multiplier array, adds a signed per-channel bias on the final beat, and presents the AB_BW-bit two's-complement result on o_acc_bias with a valid/ready handshake.
- o_acc_bias connects directly to the saturation stage's i_acc_bias.

Parameters:
- P_BW, 16, signed product input width.
- B_BW, 16, signed bias input width.
- AB_BW, 21, accumulator / output width; two's complement.
- ACC_LEN, 16, products summed per output (>=1).
- CNT_BW, $clog2(ACC_LEN) (min 1), beat counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- i_clear  in  1  synchronous abort of the current group.
- i_valid  in  1  i_product valid.
- o_ready  out  1  stage accepts a product this cycle.
- i_product  in  P_BW  signed product.
- i_bias  in  B_BW  signed bias; sampled only on the last beat of a group.
- o_valid  out  1  o_acc_bias valid.
- i_ready  in  1  downstream accepts result.
- o_acc_bias  out  AB_BW  accumulated sum plus bias.
- o_busy  out  1  group in progress (count != 0 or state S_OUT).

Interface (already decided):
- One clock; reset is asynchronous and active-high.
- Ports are named clk and rst.

Behaviour:

Reset (rst=1, asynchronous):
- State goes to S_ACC; acc=0, cnt=0.
- o_valid=0, o_acc_bias=0, o_busy=0; o_ready=1 once rst deasserts.
- Reset mid-group or mid-S_OUT discards all partial data.

States:
- S_ACC: accepting products.
- S_OUT: holding the result.

Output decodes:
- o_ready = (state==S_ACC) && !i_clear.
- o_valid = (state==S_OUT).

Beat accepted when i_valid && o_ready:
- Product is sign-extended to AB_BW.
- If cnt < ACC_LEN-1: acc <= acc + prod, cnt <= cnt+1.
- If cnt == ACC_LEN-1 (last beat): o_acc_bias <= acc + prod + sext(i_bias); acc <= 0; cnt <= 0; state <= S_OUT.

Latency and timing:
- Result is visible (o_valid=1) the cycle after the last beat is accepted.
- i_valid=0 in S_ACC: no state change; gaps between beats are allowed.

S_OUT:
- o_acc_bias and o_valid are held stable.
- o_ready=0; input beats are ignored and not counted.
- On i_ready=1: next cycle state=S_ACC, o_valid=0, o_acc_bias retains its last value.
- An output handshake and a new product are never accepted in the same cycle.
- Back-to-back throughput: ACC_LEN+1 cycles per output.

i_clear:
- Highest priority after rst; synchronous.
- acc=0, cnt=0, state=S_ACC, o_valid=0 next cycle; o_acc_bias is unchanged.
- A beat presented with i_clear is dropped (o_ready=0 that cycle).

Arithmetic:
- All sums are signed, AB_BW bits, wrap modulo 2^AB_BW; no saturation in this stage.
- With defaults, overflow is impossible: 16·2^15 + 2^15 < 2^20.
- Other parameter sets must satisfy ACC_LEN·2^(P_BW-1) + 2^(B_BW-1) ≤ 2^(AB_BW-1), or wrap applies.

ACC_LEN=1:
- Every accepted beat is a last beat: o_acc_bias = prod + bias.

Test Plan:
1. ACC_LEN=4, bias=100, products 10,20,-5,3 on consecutive cycles -> o_valid rises the cycle after the 4th beat, o_acc_bias=128 (0x000080). i_ready=1 -> o_valid drops next cycle.
2. ACC_LEN=4, products -300 ×4, bias=-100 -> o_acc_bias=-1300 (0x1FFAEC). Products 4,4,4,4, bias=0 -> 16. Products 50 ×4, bias=0 -> 200. All three values feed the downstream saturation check.
3. Backpressure: result 128 presented with i_ready=0 for 3 cycles while i_valid=1 and products=99 -> o_acc_bias stays 128, o_ready=0, beats not counted. The next group of 1,1,1,1 with bias=0 -> 4.
4. Gapped input: ACC_LEN=4, beats 7,7,7,7 separated by 2 idle cycles each, bias=-28 -> o_acc_bias=0, o_valid exactly once.
5. i_clear after 2 of 4 beats (values 1000,1000), then a fresh group 1,2,3,4 with bias=-1000 -> o_acc_bias=-990 (0x1FFC22). Repeat with rst pulsed mid-group instead -> same result; all outputs are 0 during reset.
6. Defaults (ACC_LEN=16): 16 beats of 32767 plus bias 32767 -> 557039 (0x087FEF). 16 beats of -32768 plus bias -32768 -> -557056 (0x178000). No wrap in either case.
